// File: rtl/lzd_norm_pipe.sv
// ---------------------------------------------------------------------------
// lzd_norm_pipe
//
// Two-stage pipelined leading-zero detector and normaliser with valid/ready
// flow control. Stage 1 registers the operand together with its leading-zero
// count. Stage 2 registers the operand left-shifted by min(count, limit),
// where the limit is clamped to WIDTH. A sideband tag travels with each
// operand. Sits between the mantissa adder/subtracter and the rounding stage.
//
// Parameters:
//   WIDTH  operand width (>= 2)
//   TAG_W  sideband tag width (>= 1)
//   CW     count/shift width, $clog2(WIDTH+1)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand valid
//   in_ready   operand accepted this cycle (depends combinationally on out_ready)
//   in_data    operand, bit WIDTH-1 is the MSB
//   in_lim     maximum permitted left shift for this operand
//   in_tag     sideband tag
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_data   normalised operand, zero-filled from the LSB
//   out_lz     leading-zero count (WIDTH for an all-zero operand)
//   out_shift  applied shift
//   out_zero   operand was all zeros
//   out_tag    tag of this result
// ---------------------------------------------------------------------------
module lzd_norm_pipe #(
  parameter int WIDTH = 24,
  parameter int TAG_W = 4,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CW-1:0]    in_lim,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_lz,
  output logic [CW-1:0]    out_shift,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NLEAF = (WIDTH + 7) / 8;
  localparam int PADW  = NLEAF * 8;
  localparam int PAD   = PADW - WIDTH;

  // Leading-zero count of one byte, 8 when the byte is empty.
  function automatic logic [3:0] lzd8(input logic [7:0] b);
    logic [3:0] cnt;
    cnt = 4'd8;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) cnt = 4'(7 - i);
    end
    return cnt;
  endfunction

  // Pipeline state
  logic             r_s1V;
  logic [WIDTH-1:0] r_s1Data;
  logic [CW-1:0]    r_s1Lim;
  logic [CW-1:0]    r_s1Lz;
  logic [TAG_W-1:0] r_s1Tag;

  logic             r_s2V;
  logic [WIDTH-1:0] r_s2Data;
  logic [CW-1:0]    r_s2Lz;
  logic [CW-1:0]    r_s2Shift;
  logic             r_s2Zero;
  logic [TAG_W-1:0] r_s2Tag;

  // Count tree
  logic [PADW-1:0]  w_padded;
  logic [3:0]       w_leafCnt [NLEAF];
  logic [NLEAF-1:0] w_leafNz;
  logic [CW-1:0]    w_lz;

  // Stage 2 datapath and handshake
  logic [CW-1:0]    w_limEff;
  logic [CW-1:0]    w_shift;
  logic [WIDTH-1:0] w_shifted;
  logic             w_zero;
  logic             w_s1Adv;
  logic             w_s2Adv;

  // The operand is left-justified into whole bytes. Pad bits sit below the
  // LSB, so they can never be reached by the count of a non-zero operand;
  // the all-zero case is handled separately by forcing WIDTH.
  assign w_padded = PADW'(in_data) << PAD;

  // Leaf 0 is the most significant byte.
  for (genvar l = 0; l < NLEAF; l++) begin : gLeaf
    assign w_leafNz[l]  = |w_padded[PADW-1-8*l -: 8];
    assign w_leafCnt[l] = lzd8(w_padded[PADW-1-8*l -: 8]);
  end

  // Combining level: the most significant non-empty leaf decides the count.
  // Scanning from the least significant leaf upward lets the last hit win.
  always_comb begin
    w_lz = CW'(WIDTH);
    for (int l = NLEAF - 1; l >= 0; l--) begin
      if (w_leafNz[l]) w_lz = CW'(8 * l) + CW'(w_leafCnt[l]);
    end
  end

  // Shift is min(lz, lim) with lim saturated at WIDTH. A shift of WIDTH
  // empties the operand, which matches the all-zero result.
  always_comb begin
    w_limEff  = (r_s1Lim > CW'(WIDTH)) ? CW'(WIDTH) : r_s1Lim;
    w_shift   = (r_s1Lz < w_limEff) ? r_s1Lz : w_limEff;
    w_zero    = (r_s1Lz == CW'(WIDTH));
    w_shifted = w_zero ? '0 : (r_s1Data << w_shift);
  end

  // A stage may advance when it is empty or the stage after it is leaving.
  assign w_s2Adv  = !r_s2V || out_ready;
  assign w_s1Adv  = !r_s1V || w_s2Adv;
  assign in_ready = w_s1Adv;

  // Stage 1: valid follows the input on advance; data only loads with a real
  // operand so bubbles leave the previous contents untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1V    <= 1'b0;
      r_s1Data <= '0;
      r_s1Lim  <= '0;
      r_s1Lz   <= '0;
      r_s1Tag  <= '0;
    end else if (w_s1Adv) begin
      r_s1V <= in_valid;
      if (in_valid) begin
        r_s1Data <= in_data;
        r_s1Lim  <= in_lim;
        r_s1Lz   <= w_lz;
        r_s1Tag  <= in_tag;
      end
    end
  end

  // Stage 2: holds everything while the downstream stalls a valid result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2V     <= 1'b0;
      r_s2Data  <= '0;
      r_s2Lz    <= '0;
      r_s2Shift <= '0;
      r_s2Zero  <= 1'b0;
      r_s2Tag   <= '0;
    end else if (w_s2Adv) begin
      r_s2V <= r_s1V;
      if (r_s1V) begin
        r_s2Data  <= w_shifted;
        r_s2Lz    <= r_s1Lz;
        r_s2Shift <= w_shift;
        r_s2Zero  <= w_zero;
        r_s2Tag   <= r_s1Tag;
      end
    end
  end

  assign out_valid = r_s2V;
  assign out_data  = r_s2Data;
  assign out_lz    = r_s2Lz;
  assign out_shift = r_s2Shift;
  assign out_zero  = r_s2Zero;
  assign out_tag   = r_s2Tag;

endmodule

// File: tb/tb_lzd_norm_pipe.sv
// ---------------------------------------------------------------------------
// tb_lzd_norm_pipe
//
// Self-checking bench for lzd_norm_pipe. The main WIDTH=24 instance is driven
// with directed vectors, a random back-to-back stream, a backpressure window
// and a mid-stream reset, and every output transfer is compared against an
// in-order queue of expected results. Extra instances at other widths walk a
// one-hot operand through every bit position.
// ---------------------------------------------------------------------------
module tb_lzd_norm_pipe;

  localparam int W  = 24;
  localparam int TW = 4;
  localparam int C  = $clog2(W + 1);

  typedef struct packed {
    logic [W-1:0]  d;
    logic [C-1:0]  lz;
    logic [C-1:0]  sh;
    logic          z;
    logic [TW-1:0] tag;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [C-1:0]  in_lim;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [C-1:0]  out_lz;
  logic [C-1:0]  out_shift;
  logic          out_zero;
  logic [TW-1:0] out_tag;

  int nCompared = 0;
  int nMismatch = 0;
  int inCount   = 0;
  int outCount  = 0;
  int cyc       = 0;
  logic sweepGo = 1'b0;

  exp_t expQ[$];
  int   outCyc[$];

  always #5 clk = ~clk;

  lzd_norm_pipe #(.WIDTH(W), .TAG_W(TW)) uDut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_lim(in_lim), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_lz(out_lz), .out_shift(out_shift),
    .out_zero(out_zero), .out_tag(out_tag)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference behaviour: locate the highest set bit by plain scan, clamp the
  // limit, shift.
  function automatic exp_t model(input logic [W-1:0] d, input logic [C-1:0] lim,
                                 input logic [TW-1:0] tag);
    exp_t e;
    int lz, l, sh;
    lz = W;
    for (int b = 0; b < W; b++) if (d[b]) lz = W - 1 - b;
    l  = (int'(lim) > W) ? W : int'(lim);
    sh = (lz < l) ? lz : l;
    e.lz  = C'(lz);
    e.sh  = C'(sh);
    e.z   = (d == '0);
    e.d   = d << sh;
    e.tag = tag;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Compare process: looks at the handshake half a cycle before the edge that
  // completes it. Accepted operands enter the expected queue; each output
  // transfer must match the oldest entry. A stalled result must not change.
  logic          holdPrev = 1'b0;
  logic [W-1:0]  pData;
  logic [C-1:0]  pLz, pSh;
  logic          pZero;
  logic [TW-1:0] pTag;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      expQ.delete();
      holdPrev = 1'b0;
    end else begin
      if (holdPrev) begin
        check("stall valid", 64'(out_valid), 64'd1);
        check("stall data",  64'(out_data),  64'(pData));
        check("stall lz",    64'(out_lz),    64'(pLz));
        check("stall shift", 64'(out_shift), 64'(pSh));
        check("stall zero",  64'(out_zero),  64'(pZero));
        check("stall tag",   64'(out_tag),   64'(pTag));
      end
      if (in_valid && in_ready) begin
        expQ.push_back(model(in_data, in_lim, in_tag));
        inCount++;
      end
      if (out_valid && out_ready) begin
        outCount++;
        outCyc.push_back(cyc);
        if (expQ.size() == 0) begin
          check("unexpected output", 64'd1, 64'd0);
        end else begin
          e = expQ.pop_front();
          check("sb data",  64'(out_data),  64'(e.d));
          check("sb lz",    64'(out_lz),    64'(e.lz));
          check("sb shift", 64'(out_shift), 64'(e.sh));
          check("sb zero",  64'(out_zero),  64'(e.z));
          check("sb tag",   64'(out_tag),   64'(e.tag));
        end
      end
      holdPrev = out_valid && !out_ready;
      pData = out_data; pLz = out_lz; pSh = out_shift; pZero = out_zero; pTag = out_tag;
    end
  end

  // Presents one operand and returns right after the edge that accepts it.
  task automatic applyStimulus(input logic [W-1:0] d, input logic [C-1:0] lim,
                               input logic [TW-1:0] tag);
    int k;
    in_valid = 1'b1; in_data = d; in_lim = lim; in_tag = tag;
    k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("accept timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Waits for the next result and compares it with hand-computed values.
  task automatic checkOutput(input string name, input logic [W-1:0] d, input int lz,
                             input int sh, input logic z, input logic [TW-1:0] tag);
    for (int k = 0; k < 20 && !out_valid; k++) begin
      @(posedge clk); #1;
    end
    check({name, " valid"}, 64'(out_valid), 64'd1);
    check({name, " data"},  64'(out_data),  64'(d));
    check({name, " lz"},    64'(out_lz),    64'(lz));
    check({name, " shift"}, 64'(out_shift), 64'(sh));
    check({name, " zero"},  64'(out_zero),  64'(z));
    check({name, " tag"},   64'(out_tag),   64'(tag));
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && (out_valid || expQ.size() != 0); k++) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [W-1:0] randOperand();
    logic [31:0] r;
    r = $urandom() >> $urandom_range(0, 31);
    return r[W-1:0];
  endfunction

  initial begin
    int i0, o0, stalls, stale;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_lim = '0; in_tag = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_data",  64'(out_data),  64'd0);
    check("reset out_lz",    64'(out_lz),    64'd0);
    check("reset out_shift", 64'(out_shift), 64'd0);
    check("reset out_zero",  64'(out_zero),  64'd0);
    check("reset out_tag",   64'(out_tag),   64'd0);
    check("reset in_ready",  64'(in_ready),  64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post-reset in_ready", 64'(in_ready), 64'd1);
    check("post-reset out_valid", 64'(out_valid), 64'd0);

    // Directed vectors with hand-computed results
    applyStimulus(24'h000F00, 5'd31, 4'd3);
    checkOutput("basic", 24'hF00000, 12, 12, 1'b0, 4'd3);
    applyStimulus(24'h000001, 5'd5, 4'd1);
    checkOutput("clamp", 24'h000020, 23, 5, 1'b0, 4'd1);
    applyStimulus(24'h000000, 5'd7, 4'd9);
    checkOutput("zero lim7", 24'h000000, 24, 7, 1'b1, 4'd9);
    applyStimulus(24'h000000, 5'd25, 4'd2);
    checkOutput("zero lim25", 24'h000000, 24, 24, 1'b1, 4'd2);
    applyStimulus(24'h000010, 5'd30, 4'd5);
    checkOutput("lim over width", 24'h800000, 19, 19, 1'b0, 4'd5);
    applyStimulus(24'h0000FF, 5'd0, 4'd15);
    checkOutput("lim zero", 24'h0000FF, 16, 0, 1'b0, 4'd15);
    applyStimulus(24'h800001, 5'd31, 4'd6);
    checkOutput("msb set", 24'h800001, 0, 0, 1'b0, 4'd6);
    applyStimulus(24'h012345, 5'd24, 4'd7);
    checkOutput("lim equals width", 24'h91A280, 7, 7, 1'b0, 4'd7);

    // Back-to-back random stream at full throughput
    i0 = inCount; o0 = outCount; stalls = 0;
    outCyc.delete();
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_data  = randOperand();
      in_lim   = C'($urandom_range(0, 31));
      in_tag   = TW'($urandom());
      if (!in_ready) stalls++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();
    check("stream stalls", 64'(stalls), 64'd0);
    check("stream accepted", 64'(inCount - i0), 64'd100);
    check("stream results", 64'(outCount - o0), 64'd100);
    if (outCyc.size() == 100)
      check("stream gapless", 64'(outCyc[99] - outCyc[0]), 64'd99);
    else
      check("stream result log", 64'(outCyc.size()), 64'd100);

    // Backpressure from an empty pipeline: exactly two operands fit
    i0 = inCount; o0 = outCount;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = randOperand();
      in_lim   = C'($urandom_range(0, 31));
      in_tag   = TW'(i + 8);
      @(posedge clk); #1;
    end
    check("bp accepted", 64'(inCount - i0), 64'd2);
    check("bp in_ready", 64'(in_ready), 64'd0);
    check("bp out_valid", 64'(out_valid), 64'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    check("bp results", 64'(outCount - o0), 64'd2);
    check("bp queue empty", 64'(expQ.size()), 64'd0);

    // Asynchronous reset with both stages full
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 24'h00ABCD; in_lim = 5'd31; in_tag = 4'hA;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("full before reset", 64'(in_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset out_valid", 64'(out_valid), 64'd0);
    check("async reset out_data",  64'(out_data),  64'd0);
    check("async reset out_lz",    64'(out_lz),    64'd0);
    check("async reset out_shift", 64'(out_shift), 64'd0);
    check("async reset out_tag",   64'(out_tag),   64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) stale++;
      @(posedge clk); #1;
    end
    check("no stale result", 64'(stale), 64'd0);

    // Width sweep on the auxiliary instances
    sweepGo = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      if (gSweep[0].done && gSweep[1].done && gSweep[2].done &&
          gSweep[3].done && gSweep[4].done) break;
      @(posedge clk);
    end
    check("sweep finished", 64'(gSweep[0].done && gSweep[1].done && gSweep[2].done &&
                                gSweep[3].done && gSweep[4].done), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

  // One-hot walk at each width: with the limit at WIDTH the shift is never
  // clamped, so a non-zero result always has its MSB set.
  for (genvar g = 0; g < 5; g++) begin : gSweep
    localparam int SW = (g == 0) ? 2 : (g == 1) ? 8 : (g == 2) ? 13 : (g == 3) ? 32 : 53;
    localparam int SC = $clog2(SW + 1);

    logic           sValid, sReady, sOutValid, sOutZero;
    logic [SW-1:0]  sData, sOutData;
    logic [SC-1:0]  sLim, sOutLz, sOutShift;
    logic [0:0]     sTag, sOutTag;
    logic           done = 1'b0;

    lzd_norm_pipe #(.WIDTH(SW), .TAG_W(1)) uSweep (
      .clk(clk), .rst_n(rst_n),
      .in_valid(sValid), .in_ready(sReady),
      .in_data(sData), .in_lim(sLim), .in_tag(sTag),
      .out_valid(sOutValid), .out_ready(1'b1),
      .out_data(sOutData), .out_lz(sOutLz), .out_shift(sOutShift),
      .out_zero(sOutZero), .out_tag(sOutTag)
    );

    initial begin
      logic [SW-1:0] one;
      logic [SW-1:0] expData;
      int expLz;
      one = '0;
      one[0] = 1'b1;
      sValid = 1'b0; sData = '0; sLim = SC'(SW); sTag = 1'b0;
      wait (sweepGo);
      @(posedge clk); #1;
      for (int p = -1; p < SW; p++) begin
        sData   = (p < 0) ? '0 : (one << p);
        sTag    = p[0];
        expLz   = (p < 0) ? SW : SW - 1 - p;
        expData = (p < 0) ? '0 : (one << (SW - 1));
        sValid  = 1'b1;
        check($sformatf("W%0d ready", SW), 64'(sReady), 64'd1);
        @(posedge clk); #1;
        sValid = 1'b0;
        for (int k = 0; k < 8 && !sOutValid; k++) begin
          @(posedge clk); #1;
        end
        check($sformatf("W%0d pos%0d valid", SW, p), 64'(sOutValid), 64'd1);
        check($sformatf("W%0d pos%0d lz", SW, p),    64'(sOutLz),    64'(expLz));
        check($sformatf("W%0d pos%0d shift", SW, p), 64'(sOutShift), 64'(expLz));
        check($sformatf("W%0d pos%0d data", SW, p),  64'(sOutData),  64'(expData));
        check($sformatf("W%0d pos%0d zero", SW, p),  64'(sOutZero),  64'(p < 0));
        check($sformatf("W%0d pos%0d tag", SW, p),   64'(sOutTag),   64'(p[0]));
        @(posedge clk); #1;
      end
      done = 1'b1;
    end
  end

endmodule
